// File: rtl/lcd_seq_pkg.sv
// Shared opcode constants, opcode classes and FSM state encoding for the
// LCD command sequencer.
package lcd_seq_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_WRITE = 4'd0;
  localparam opcode_t OP_CLR   = 4'd1;
  localparam opcode_t OP_HOME  = 4'd2;
  localparam opcode_t OP_ON    = 4'd3;
  localparam opcode_t OP_OFF   = 4'd4;
  localparam opcode_t OP_INV   = 4'd5;
  localparam opcode_t OP_NORM  = 4'd6;
  localparam opcode_t OP_CONTR = 4'd7;
  localparam opcode_t OP_SCRL  = 4'd8;
  localparam opcode_t OP_ROT   = 4'd9;
  localparam opcode_t OP_MIRX  = 4'd10;
  localparam opcode_t OP_MIRY  = 4'd11;

  localparam opcode_t OP_VALID_MAX = 4'd11;

  typedef enum logic [1:0] {
    OPC_VALID    = 2'd0,
    OPC_INVALID  = 2'd1,
    OPC_TERMINAL = 2'd2
  } op_class_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RD     = 3'd1;
  localparam logic [2:0] ST_LATCH  = 3'd2;
  localparam logic [2:0] ST_ISSUE  = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;
  localparam logic [2:0] ST_FINISH = 3'd6;

endpackage

// File: rtl/lcd_cmd_seq_if.sv
// Command-ROM read bus plus LCD controller command handshake.
// master = sequencer side, slave = ROM / LCD controller side.
interface lcd_cmd_seq_if
  import lcd_seq_pkg::*;
#(
  parameter int ADDR_W = 6
);

  logic              CROM_rd;
  logic [ADDR_W-1:0] CROM_A;
  logic [7:0]        CROM_Q;
  opcode_t           cmd;
  logic              cmd_valid;
  logic              busy;
  logic              lcd_done;

  modport master (
    output CROM_rd,
    output CROM_A,
    input  CROM_Q,
    output cmd,
    output cmd_valid,
    input  busy,
    input  lcd_done
  );

  modport slave (
    input  CROM_rd,
    input  CROM_A,
    output CROM_Q,
    input  cmd,
    input  cmd_valid,
    output busy,
    output lcd_done
  );

endinterface

// File: rtl/lcd_seq_op_check.sv
// Combinational opcode classifier: OP_WRITE ends a script, the named
// opcodes are issued, anything above OP_VALID_MAX is skipped.
module lcd_seq_op_check
  import lcd_seq_pkg::*;
(
  input  opcode_t   i_op,
  output op_class_t o_class
);

  always_comb begin
    o_class = OPC_INVALID;
    case (i_op)
      OP_WRITE: o_class = OPC_TERMINAL;
      OP_CLR, OP_HOME, OP_ON, OP_OFF, OP_INV, OP_NORM,
      OP_CONTR, OP_SCRL, OP_ROT, OP_MIRX, OP_MIRY:
        o_class = OPC_VALID;
      default:
        o_class = (i_op > OP_VALID_MAX) ? OPC_INVALID : OPC_VALID;
    endcase
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: walks a command-ROM script and feeds opcodes to the
// LCD controller. Define LCD_SEQ_REPEAT_EN to honour the ROM repeat field.
module lcd_cmd_seq
  import lcd_seq_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 4
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  lcd_cmd_seq_if.master     bus,
  output logic              seq_busy,
  output logic              seq_done,
  output logic [CNT_W-1:0]  bad_cnt
);

  localparam logic [CNT_W-1:0] BAD_MAX = '1;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  opcode_t           r_op;
  opcode_t           r_cmd;
  logic [3:0]        r_rep_cnt;
  logic              r_terminal;
  logic              r_seq_busy;
  logic              r_seq_done;
  logic [CNT_W-1:0]  r_bad_cnt;

  op_class_t         w_class;
  logic [3:0]        w_rep_field;
  logic              w_issue;

  lcd_seq_op_check u_op_check (
    .i_op    (bus.CROM_Q[3:0]),
    .o_class (w_class)
  );

`ifdef LCD_SEQ_REPEAT_EN
  assign w_rep_field = bus.CROM_Q[7:4];
`else
  logic w_unused_rep;
  assign w_unused_rep = ^bus.CROM_Q[7:4];
  assign w_rep_field  = 4'd0;
`endif

  // The strobe is combinational so the first command leaves in the ISSUE
  // cycle itself; cmd shows the live opcode only while it is strobed.
  assign w_issue       = (r_state == ST_ISSUE) && !bus.busy;
  assign bus.cmd_valid = w_issue;
  assign bus.cmd       = w_issue ? r_op : r_cmd;
  assign bus.CROM_rd   = (r_state == ST_RD);
  assign bus.CROM_A    = r_addr;
  assign seq_busy      = r_seq_busy;
  assign seq_done      = r_seq_done;
  assign bad_cnt       = r_bad_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_op       <= OP_WRITE;
      r_cmd      <= OP_WRITE;
      r_rep_cnt  <= 4'd0;
      r_terminal <= 1'b0;
      r_seq_busy <= 1'b0;
      r_seq_done <= 1'b0;
      r_bad_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr     <= base_addr;
            r_seq_busy <= 1'b1;
            r_state    <= ST_RD;
          end
        end

        ST_RD: begin
          r_state <= ST_LATCH;
        end

        ST_LATCH: begin
          r_op       <= bus.CROM_Q[3:0];
          r_rep_cnt  <= w_rep_field;
          r_terminal <= (w_class == OPC_TERMINAL);
          if (w_class == OPC_INVALID) begin
            if (r_bad_cnt != BAD_MAX) begin
              r_bad_cnt <= r_bad_cnt + 1'b1;
            end
            r_addr  <= r_addr + 1'b1;
            r_state <= ST_RD;
          end else begin
            r_state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (!bus.busy) begin
            r_cmd   <= r_op;
            r_state <= ST_ACK;
          end
        end

        ST_ACK: begin
          if (bus.busy) begin
            r_state <= ST_WAIT;
          end
        end

        // A terminal write ends on write-back; its repeat field never counts.
        ST_WAIT: begin
          if (r_terminal) begin
            if (bus.lcd_done) begin
              r_seq_busy <= 1'b0;
              r_seq_done <= 1'b1;
              r_state    <= ST_FINISH;
            end
          end else if (!bus.busy) begin
            if (r_rep_cnt != 4'd0) begin
              r_rep_cnt <= r_rep_cnt - 1'b1;
              r_state   <= ST_ISSUE;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= ST_RD;
            end
          end
        end

        ST_FINISH: begin
          r_state <= ST_FINISH;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6: command-ROM address width (64 script entries).
REQ-002 The block SHALL have parameter CNT_W, default 4: width of the invalid-opcode counter.
REQ-003 The block SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port start  in  1  one-cycle request to run a script.
REQ-006 The block SHALL have port base_addr  in  ADDR_W  first script entry, sampled with start.
REQ-007 The block SHALL have port CROM_rd  out  1  command-ROM read strobe.
REQ-008 The block SHALL have port CROM_A  out  ADDR_W  command-ROM address.
REQ-009 The block SHALL have port CROM_Q  in  8  ROM entry, valid the cycle after CROM_rd: [7:4] repeat-1, [3:0] opcode.
REQ-010 The block SHALL have port cmd  out  4  opcode to the LCD controller.
REQ-011 The block SHALL have port cmd_valid  out  1  one-cycle command strobe to the LCD controller.
REQ-012 The block SHALL have port busy  in  1  LCD controller busy.
REQ-013 The block SHALL have port lcd_done  in  1  LCD controller write-back complete.
REQ-014 The block SHALL have port seq_busy  out  1  script running.
REQ-015 The block SHALL have port seq_done  out  1  script finished (sticky).
REQ-016 The block SHALL have port bad_cnt  out  CNT_W  count of skipped invalid opcodes, saturating.

Function
REQ-017 The FSM SHALL use states IDLE, RD, LATCH, ISSUE, ACK, WAIT and FINISH.
REQ-018 IDLE: on start=1, capture base_addr into CROM_A, set seq_busy=1 and go to RD; start SHALL be ignored in every other state.
REQ-019 RD: assert CROM_rd for exactly one cycle, then go to LATCH.
REQ-020 LATCH: capture CROM_Q, load rep_cnt from [7:4] and the opcode from [3:0]; opcodes 0-11 go to ISSUE.
REQ-021 LATCH: opcodes 12-15 SHALL increment bad_cnt (saturating at 2^CNT_W-1), increment CROM_A and go to RD; no cmd_valid is issued.
REQ-022 ISSUE: wait until busy=0, then drive cmd=opcode and cmd_valid=1 for exactly one cycle and go to ACK.
REQ-023 ACK: wait until busy=1, then go to WAIT.
REQ-024 WAIT, opcode 0: wait for lcd_done=1, then go to FINISH.
REQ-025 WAIT, opcodes 1-11, when busy=0: if rep_cnt≠0, decrement rep_cnt and return to ISSUE; otherwise increment CROM_A and go to RD.
REQ-026 CROM_A SHALL wrap from 2^ADDR_W-1 to 0.
REQ-027 A script without opcode 0 SHALL run indefinitely.
REQ-028 FINISH: seq_busy=0 and seq_done=1, held until reset; FINISH is terminal.
REQ-029 Opcode 0 SHALL be issued exactly once, regardless of its repeat field.
REQ-030 busy=1 on entry to ISSUE (e.g. the LCD is still fetching its image after reset) SHALL stall without issuing.
REQ-031 Command latency SHALL be 3 cycles from start to the first cmd_valid when busy=0 (RD, LATCH, ISSUE).
REQ-032 cmd SHALL hold its last value when cmd_valid=0.

Reset
REQ-033 reset=0 SHALL force, asynchronously, state=IDLE, CROM_rd=0, CROM_A=0, cmd=0, cmd_valid=0, seq_busy=0, seq_done=0, bad_cnt=0 and rep_cnt=0.
REQ-034 Reset asserted mid-script SHALL abort the script immediately; no further cmd_valid is issued until a new start.

Configuration
REQ-035 With LCD_SEQ_REPEAT_EN defined, the [7:4] repeat field SHALL be honoured (1-16 issues per entry).
REQ-036 Without LCD_SEQ_REPEAT_EN, rep_cnt SHALL be held at 0, so every entry is issued once and [7:4] is ignored.

Structure
REQ-037 Shared package lcd_seq_pkg SHALL hold the opcode constants (OP_WRITE=0 … OP_MIRY=11), the opcode-valid limit (11) and the FSM state encoding.
REQ-038 Sub-module lcd_seq_op_check SHALL classify an opcode combinationally as valid, invalid or terminal.

Verification
REQ-039 Reset release, busy=1 for 70 cycles, start with base_addr=0, ROM[0]=0x01 -> first cmd_valid in the cycle after busy falls, cmd=1.
REQ-040 ROM[0..2]=0x03,0x04,0x00 with a compliant LCD model -> cmd sequence 3,4,0, then seq_done=1 one cycle after lcd_done.
REQ-041 ROM[0]=0x37 with LCD_SEQ_REPEAT_EN -> four cmd=7 pulses, each after busy returns low; without the macro -> one pulse.
REQ-042 ROM[0..2]=0x0E,0x0F,0x00 -> no cmd_valid for the two invalid entries, bad_cnt=2, then cmd=0.
REQ-043 base_addr=63, ROM[63]=0x05, ROM[0]=0x00 -> CROM_A goes 63 then 0; cmd 5 then 0 is issued.
REQ-044 reset=0 while in WAIT -> all outputs return to reset values in the same cycle; the next start restarts the script from base_addr.
